// File: rtl/tune_input_ctrl_pkg.sv
// Shared defaults and selection encodings for the tuning front panel.
package tune_input_ctrl_pkg;

  localparam int unsigned NUM_CHAN_DEF  = 5;
  localparam int unsigned NUM_PARAM_DEF = 4;

  typedef enum logic [3:0] {
    PARAM_KI = 4'd0,
    PARAM_KP = 4'd1,
    PARAM_TV = 4'd2
  } param_sel_e;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input int unsigned n);
    return ((32'(v) + 32'd1) >= n) ? '0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter debouncer and rising-edge press detector
// for one raw push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/tune_input_ctrl.sv
// Front-panel controller: debounced buttons drive inc/dec pulses with
// hold-to-repeat, plus channel/parameter selection with wrap-around.
module tune_input_ctrl
  import tune_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 2500000,
  parameter int unsigned NUM_CHAN        = NUM_CHAN_DEF,
  parameter int unsigned NUM_PARAM       = NUM_PARAM_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_chan,
  input  logic       btn_param,
  output logic       inc_const,
  output logic       dec_const,
  output logic [3:0] choose_c,
  output logic [3:0] choose
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  logic w_inc_lvl, w_inc_press, w_dec_lvl, w_dec_press;
  logic w_chan_press, w_param_press;
  logic w_unused_chan_lvl, w_unused_param_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .i_btn(btn_inc), .o_level(w_inc_lvl), .o_press(w_inc_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .rst(rst), .i_btn(btn_dec), .o_level(w_dec_lvl), .o_press(w_dec_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_chan (
    .clk(clk), .rst(rst), .i_btn(btn_chan), .o_level(w_unused_chan_lvl), .o_press(w_chan_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_param (
    .clk(clk), .rst(rst), .i_btn(btn_param), .o_level(w_unused_param_lvl), .o_press(w_param_press));

  logic [HW-1:0] r_inc_cnt, r_dec_cnt;
  logic          r_inc_const, r_dec_const;
  logic [3:0]    r_choose_c, r_choose;

  logic w_both, w_sel_upd, w_inc_rep, w_dec_rep, w_inc_req, w_dec_req;

  always_comb begin
    w_both    = w_inc_lvl & w_dec_lvl;
    w_sel_upd = w_chan_press | w_param_press;
    w_inc_rep = (r_inc_cnt == HW'(HOLD_CYCLES - 1));
    w_dec_rep = (r_dec_cnt == HW'(HOLD_CYCLES - 1));
    w_inc_req = w_inc_lvl & ~w_both & (w_inc_press | w_inc_rep);
    w_dec_req = w_dec_lvl & ~w_both & (w_dec_press | w_dec_rep);
  end

  // After the first HOLD wait the counter reloads to HOLD-REPEAT, so the same
  // terminal compare yields the REPEAT period.
  always_ff @(posedge clk) begin
    if (rst || !w_inc_lvl || w_both || w_inc_press) begin
      r_inc_cnt <= '0;
    end else if (w_inc_rep) begin
      r_inc_cnt <= HW'(HOLD_CYCLES - REPEAT_CYCLES);
    end else begin
      r_inc_cnt <= r_inc_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_dec_lvl || w_both || w_dec_press) begin
      r_dec_cnt <= '0;
    end else if (w_dec_rep) begin
      r_dec_cnt <= HW'(HOLD_CYCLES - REPEAT_CYCLES);
    end else begin
      r_dec_cnt <= r_dec_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc_const <= 1'b0;
      r_dec_const <= 1'b0;
      r_choose_c  <= '0;
      r_choose    <= PARAM_KI;
    end else begin
      // A selection change swallows any coincident pulse.
      r_inc_const <= w_inc_req & ~w_dec_req & ~w_sel_upd;
      r_dec_const <= w_dec_req & ~w_inc_req & ~w_sel_upd;
      if (w_chan_press) begin
        r_choose_c <= wrap_inc(r_choose_c, NUM_CHAN);
        r_choose   <= PARAM_KI;
      end else if (w_param_press) begin
        r_choose <= wrap_inc(r_choose, NUM_PARAM);
      end
    end
  end

  assign inc_const = r_inc_const;
  assign dec_const = r_dec_const;
  assign choose_c  = r_choose_c;
  assign choose    = r_choose;

endmodule

// File: tb/tb_tune_input_ctrl.sv
// Randomized scoreboard bench for tune_input_ctrl against a behavioural model.
module tb_tune_input_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int NCH  = 5;
  localparam int NPA  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_chan = 1'b0, btn_param = 1'b0;
  logic       inc_const, dec_const;
  logic [3:0] choose_c, choose;

  always #5 clk = ~clk;

  tune_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .NUM_CHAN(NCH),
    .NUM_PARAM(NPA)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_chan(btn_chan), .btn_param(btn_param),
    .inc_const(inc_const), .dec_const(dec_const),
    .choose_c(choose_c), .choose(choose)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    bit inc;
    bit dec;
    int cc;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Model state: raw-level history per button (bit j = value sampled j edges ago),
  // accepted levels, press flags, and the edge where each hold timer last restarted.
  bit [5:0] hist[4];
  bit       lvl[4];
  bit       prs[4];
  int       anc[2];
  int       m_cc = 0, m_ch = 0;

  function automatic bit repeat_due(int d);
    return (d >= HOLD) && (((d - HOLD) % REP) == 0);
  endfunction

  task automatic model_step(input int e);
    bit raw[4];
    bit fire[2];
    bit both, sel, newl;
    int ncc, nch;
    ev_t ev;
    raw[0] = btn_inc; raw[1] = btn_dec; raw[2] = btn_chan; raw[3] = btn_param;
    fire[0] = 1'b0; fire[1] = 1'b0;
    ncc = m_cc; nch = m_ch;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        hist[b] = '0; lvl[b] = 1'b0; prs[b] = 1'b0;
      end
      ncc = 0; nch = 0;
    end else begin
      both = lvl[0] && lvl[1];
      sel  = prs[2] || prs[3];
      for (int b = 0; b < 2; b++) begin
        fire[b] = lvl[b] && !both && !sel && (prs[b] || repeat_due(e - anc[b]));
        if (!lvl[b] || both || prs[b]) anc[b] = e;
      end
      if (prs[2]) begin
        ncc = (m_cc + 1) % NCH; nch = 0;
      end else if (prs[3]) begin
        nch = (m_ch + 1) % NPA;
      end
      for (int b = 0; b < 4; b++) begin
        hist[b] = {hist[b][4:0], raw[b]};
        newl = (hist[b][5:2] == {4{~lvl[b]}}) ? ~lvl[b] : lvl[b];
        prs[b] = newl && !lvl[b];
        lvl[b] = newl;
      end
    end
    if (fire[0] || fire[1] || ncc != m_cc || nch != m_ch) begin
      ev.edge_n = e; ev.inc = fire[0]; ev.dec = fire[1]; ev.cc = ncc; ev.ch = nch;
      exp_q.push_back(ev);
    end
    m_cc = ncc; m_ch = nch;
  endtask

  // Monitor: any pulse or selection change must match the head of the queue.
  int prev_cc = 0, prev_ch = 0;
  initial begin
    int e;
    ev_t ev;
    forever begin
      @(negedge clk);
      e = cyc;
      while (exp_q.size() > 0 && exp_q[0].edge_n < e) begin
        ev = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missed_event edge=%0d expected inc=%0d dec=%0d cc=%0d ch=%0d",
                 ev.edge_n, ev.inc, ev.dec, ev.cc, ev.ch);
      end
      if (inc_const || dec_const || int'(choose_c) != prev_cc || int'(choose) != prev_ch) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event edge=%0d got inc=%0d dec=%0d cc=%0d ch=%0d, required no event",
                   e, inc_const, dec_const, choose_c, choose);
        end else begin
          ev = exp_q.pop_front();
          if (ev.edge_n != e || ev.inc != inc_const || ev.dec != dec_const ||
              ev.cc != int'(choose_c) || ev.ch != int'(choose)) begin
            failures++;
            $display("FAIL event edge=%0d got inc=%0d dec=%0d cc=%0d ch=%0d, required edge=%0d inc=%0d dec=%0d cc=%0d ch=%0d",
                     e, inc_const, dec_const, choose_c, choose,
                     ev.edge_n, ev.inc, ev.dec, ev.cc, ev.ch);
          end
        end
      end
      prev_cc = int'(choose_c);
      prev_ch = int'(choose);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(cyc);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input bit [3:0] mask, input int hold, input int gap);
    {btn_param, btn_chan, btn_dec, btn_inc} = mask;
    run(hold);
    {btn_param, btn_chan, btn_dec, btn_inc} = 4'b0000;
    run(gap);
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      hist[b] = '0; lvl[b] = 1'b0; prs[b] = 1'b0;
    end
    anc[0] = 0; anc[1] = 0;

    rst = 1'b1;
    run(3);
    rst = 1'b0;
    checks++;
    if (inc_const !== 1'b0 || dec_const !== 1'b0 || choose_c !== 4'd0 || choose !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got inc=%0d dec=%0d cc=%0d ch=%0d, required all 0",
               inc_const, dec_const, choose_c, choose);
    end
    run(100);

    press(4'b0001, 3, 20);            // glitch on inc
    press(4'b0001, 10, 20);           // single inc
    press(4'b0010, 50, 10);           // dec with repeats
    press(4'b0010, 30, 20);           // re-press restarts hold
    press(4'b1000, 8, 10);
    press(4'b1000, 8, 10);            // choose = 2
    for (int i = 0; i < 5; i++) press(4'b0100, 8, 10);
    for (int i = 0; i < 4; i++) press(4'b1000, 8, 10);
    press(4'b0011, 40, 20);           // inc+dec together
    press(4'b1100, 8, 20);            // chan+param together

    btn_inc = 1'b1;
    run(35);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);
    btn_inc = 1'b0;
    run(20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) btn_inc   = ~btn_inc;
      if ($urandom_range(0, 99) < 3) btn_dec   = ~btn_dec;
      if ($urandom_range(0, 99) < 2) btn_chan  = ~btn_chan;
      if ($urandom_range(0, 99) < 2) btn_param = ~btn_param;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    {btn_param, btn_chan, btn_dec, btn_inc} = 4'b0000;
    run(60);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending events, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
